// File: rtl/apb_bfm_pkg.sv
// apb_bfm_pkg - shared types and constants for the PM-side APB initiator.
//   apb_state_e : transfer sequencer states (IDLE/SETUP/ACCESS/RESP)
//   APB_AW/DW   : APB address and data widths
//   apb_rsp_t   : response record returned to the command issuer
package apb_bfm_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              err;
        logic              timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_pm_master_if.sv
// apb_pm_master_if - PM-side APB bus bundle.
//   master modport : drives PSEL/PADDR/PWRITE/PENABLE/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave modport  : the mirror image, used by the bridge or a bench model
interface apb_pm_master_if;

    logic                           PSEL_PM;
    logic [apb_bfm_pkg::APB_AW-1:0] PADDR_PM;
    logic                           PWRITE_PM;
    logic                           PENABLE_PM;
    logic [apb_bfm_pkg::APB_DW-1:0] PWDATA_PM;
    logic [apb_bfm_pkg::APB_DW-1:0] PRDATA_PM;
    logic                           PREADY_PM;
    logic                           PSLVERR_PM;

    modport master (
        output PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
        input  PRDATA_PM, PREADY_PM, PSLVERR_PM
    );

    modport slave (
        input  PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
        output PRDATA_PM, PREADY_PM, PSLVERR_PM
    );

endinterface

// File: rtl/apb_pm_wdog.sv
// apb_pm_wdog - ACCESS-phase timeout counter.
//   PCLK_PM, PRESETN_PM : clock, async active-low reset
//   load                : restart the count (asserted in SETUP)
//   en                  : count one stalled ACCESS cycle
//   expire              : terminal count reached; the current stalled cycle is the last one
// Down-counter loaded with LIMIT-1, so expire after LIMIT-1 stalled edges matches an
// up-count compare against LIMIT-1. LIMIT = 0 never expires.
module apb_pm_wdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic PCLK_PM,
    input  logic PRESETN_PM,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned LOAD_VAL = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam int unsigned CW       = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(LOAD_VAL);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = (LIMIT != 0) && (cnt_q == '0);

endmodule

// File: rtl/apb_pm_master.sv
// apb_pm_master - single-outstanding APB initiator for the PM side of the CDC bridge BFM.
//   PCLK_PM, PRESETN_PM           : clock, async active-low reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA : command handshake
//   apb (apb_pm_master_if.master) : APB bus
//   RSP_VALID/READY/RDATA/ERR/TIMEOUT : response handshake
//   BUSY                          : a transfer is in flight
// Optional build macro APB_PM_MASTER_STATS_EN adds parameter CNT_W, input STAT_CLR and
// saturating counters STAT_RD/STAT_WR/STAT_ERR/STAT_TO.
//
// state  | meaning
// IDLE   | ready for a command; APB idle
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | response held until RSP_READY; APB idle
module apb_pm_master
    import apb_bfm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
`ifdef APB_PM_MASTER_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic              PCLK_PM,
    input  logic              PRESETN_PM,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [APB_AW-1:0] CMD_ADDR,
    input  logic [APB_DW-1:0] CMD_WDATA,
    apb_pm_master_if.master   apb,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [APB_DW-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              BUSY
`ifdef APB_PM_MASTER_STATS_EN
    ,
    input  logic              STAT_CLR,
    output logic [CNT_W-1:0]  STAT_RD,
    output logic [CNT_W-1:0]  STAT_WR,
    output logic [CNT_W-1:0]  STAT_ERR,
    output logic [CNT_W-1:0]  STAT_TO
`endif
);

    apb_state_e        state_q, state_d;
    apb_rsp_t          rsp_q, rsp_d;
    logic [APB_AW-1:0] paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic              pwrite_q;
    logic              wdog_expire;

    apb_pm_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .PCLK_PM    (PCLK_PM),
        .PRESETN_PM (PRESETN_PM),
        .load       (state_q == SETUP),
        .en         ((state_q == ACCESS) && !apb.PREADY_PM),
        .expire     (wdog_expire)
    );

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            state_q  <= IDLE;
            rsp_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            if ((state_q == IDLE) && CMD_VALID) begin
                paddr_q  <= CMD_ADDR;
                pwdata_q <= CMD_WDATA;
                pwrite_q <= CMD_WRITE;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rsp_d          = rsp_q;
        CMD_READY      = 1'b0;
        RSP_VALID      = 1'b0;
        apb.PSEL_PM    = 1'b0;
        apb.PENABLE_PM = 1'b0;
        case (state_q)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) state_d = SETUP;
            end
            SETUP: begin
                apb.PSEL_PM = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                apb.PSEL_PM    = 1'b1;
                apb.PENABLE_PM = 1'b1;
                // PREADY is checked first so a completing slave beats the timeout.
                if (apb.PREADY_PM) begin
                    state_d       = RESP;
                    rsp_d.rdata   = pwrite_q ? '0 : apb.PRDATA_PM;
                    rsp_d.err     = apb.PSLVERR_PM;
                    rsp_d.timeout = 1'b0;
                end else if (wdog_expire) begin
                    state_d       = RESP;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign apb.PADDR_PM  = paddr_q;
    assign apb.PWDATA_PM = pwdata_q;
    assign apb.PWRITE_PM = pwrite_q;
    assign RSP_RDATA     = rsp_q.rdata;
    assign RSP_ERR       = rsp_q.err;
    assign RSP_TIMEOUT   = rsp_q.timeout;
    assign BUSY          = (state_q != IDLE);

`ifdef APB_PM_MASTER_STATS_EN
    logic             rsp_enter;
    logic [CNT_W-1:0] stat_rd_q, stat_wr_q, stat_err_q, stat_to_q;

    assign rsp_enter = (state_q == ACCESS) && (state_d == RESP);

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
            stat_to_q  <= '0;
        end else if (STAT_CLR) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
            stat_to_q  <= '0;
        end else if (rsp_enter) begin
            if (!pwrite_q && !(&stat_rd_q))     stat_rd_q  <= stat_rd_q + 1'b1;
            if (pwrite_q && !(&stat_wr_q))      stat_wr_q  <= stat_wr_q + 1'b1;
            if (rsp_d.err && !(&stat_err_q))    stat_err_q <= stat_err_q + 1'b1;
            if (rsp_d.timeout && !(&stat_to_q)) stat_to_q  <= stat_to_q + 1'b1;
        end
    end

    assign STAT_RD  = stat_rd_q;
    assign STAT_WR  = stat_wr_q;
    assign STAT_ERR = stat_err_q;
    assign STAT_TO  = stat_to_q;
`endif

endmodule

// File: tb/tb_apb_pm_master.sv
// tb_apb_pm_master - directed bench for apb_pm_master.
// dut runs with TIMEOUT_CYCLES = 8 against a reactive wait-state slave; dut_z runs with
// the timeout disabled and a slave that never answers until told to.
// Statistics checks are compiled in when APB_PM_MASTER_STATS_EN is defined.
module tb_apb_pm_master;

    logic        PCLK_PM = 1'b0;
    logic        PRESETN_PM;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;

    logic        z_cmd_valid, z_cmd_ready, z_cmd_write;
    logic [31:0] z_cmd_addr, z_cmd_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_rsp_timeout, z_busy;
    logic [31:0] z_rsp_rdata;

`ifdef APB_PM_MASTER_STATS_EN
    logic        stat_clr, z_stat_clr;
    logic [15:0] stat_rd, stat_wr, stat_err, stat_to;
    logic [15:0] z_stat_rd, z_stat_wr, z_stat_err, z_stat_to;
`endif

    apb_pm_master_if apb_m ();
    apb_pm_master_if apb_z ();

    always #5 PCLK_PM = ~PCLK_PM;

    apb_pm_master #(.TIMEOUT_CYCLES(8)) dut (
        .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .apb(apb_m),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err), .RSP_TIMEOUT(rsp_timeout), .BUSY(busy)
`ifdef APB_PM_MASTER_STATS_EN
        , .STAT_CLR(stat_clr), .STAT_RD(stat_rd), .STAT_WR(stat_wr),
        .STAT_ERR(stat_err), .STAT_TO(stat_to)
`endif
    );

    apb_pm_master #(.TIMEOUT_CYCLES(0)) dut_z (
        .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM),
        .CMD_VALID(z_cmd_valid), .CMD_READY(z_cmd_ready), .CMD_WRITE(z_cmd_write),
        .CMD_ADDR(z_cmd_addr), .CMD_WDATA(z_cmd_wdata), .apb(apb_z),
        .RSP_VALID(z_rsp_valid), .RSP_READY(z_rsp_ready), .RSP_RDATA(z_rsp_rdata),
        .RSP_ERR(z_rsp_err), .RSP_TIMEOUT(z_rsp_timeout), .BUSY(z_busy)
`ifdef APB_PM_MASTER_STATS_EN
        , .STAT_CLR(z_stat_clr), .STAT_RD(z_stat_rd), .STAT_WR(z_stat_wr),
        .STAT_ERR(z_stat_err), .STAT_TO(z_stat_to)
`endif
    );

    // Reactive slave: n_wait stalled ACCESS cycles, then PREADY with sl_rdata/sl_err.
    int          n_wait   = 0;
    int          wait_ctr = 0;
    logic [31:0] sl_rdata = 32'h0;
    logic        sl_err   = 1'b0;

    always @(negedge PCLK_PM) begin
        if (apb_m.PSEL_PM && apb_m.PENABLE_PM) begin
            if (wait_ctr < n_wait) begin
                apb_m.PREADY_PM = 1'b0;
                wait_ctr++;
            end else begin
                apb_m.PREADY_PM  = 1'b1;
                apb_m.PRDATA_PM  = sl_rdata;
                apb_m.PSLVERR_PM = sl_err;
            end
        end else begin
            apb_m.PREADY_PM  = 1'b0;
            apb_m.PSLVERR_PM = 1'b0;
            apb_m.PRDATA_PM  = 32'hA5A5_A5A5;
            wait_ctr         = 0;
        end
    end

    // Bus monitor on the main instance.
    int psel_cnt = 0, pen_cnt = 0, gap_run = 0, last_gap = 0;

    always @(negedge PCLK_PM) begin
        if (apb_m.PSEL_PM) psel_cnt++;
        if (apb_m.PENABLE_PM) begin
            pen_cnt++;
            if (gap_run > 0) last_gap = gap_run;
            gap_run = 0;
        end else begin
            gap_run++;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK_PM);
        #1;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && (n < budget)) begin
            tick();
            n++;
        end
        if (!rsp_valid) check("rsp_wait_expired", 32'(rsp_valid), 1);
    endtask

    task automatic rsp_ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

`ifdef APB_PM_MASTER_STATS_EN
    task automatic simple_xfer(input logic wr, input logic [31:0] addr);
        issue(wr, addr, 32'h0);
        wait_rsp(20);
        rsp_ack();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    int base_sel, base_en, hi, drain;

    initial begin
        PRESETN_PM  = 1'b0;
        cmd_valid   = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready   = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_write = 1'b0; z_cmd_addr = '0; z_cmd_wdata = '0;
        z_rsp_ready = 1'b0;
        apb_z.PREADY_PM = 1'b0; apb_z.PRDATA_PM = '0; apb_z.PSLVERR_PM = 1'b0;
`ifdef APB_PM_MASTER_STATS_EN
        stat_clr = 1'b0; z_stat_clr = 1'b0;
`endif
        #22 PRESETN_PM = 1'b1;
        tick();

        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_psel", 32'(apb_m.PSEL_PM), 0);
        check("rst_penable", 32'(apb_m.PENABLE_PM), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_paddr", apb_m.PADDR_PM, 0);

        // Zero-wait write.
        n_wait = 0; sl_rdata = 32'hFFFF_FFFF; sl_err = 1'b0;
        base_sel = psel_cnt; base_en = pen_cnt;
        issue(1'b1, 32'h0100_0004, 32'hDEAD_BEEF);
        check("w0_setup_psel", 32'(apb_m.PSEL_PM), 1);
        check("w0_setup_penable", 32'(apb_m.PENABLE_PM), 0);
        check("w0_setup_paddr", apb_m.PADDR_PM, 32'h0100_0004);
        check("w0_setup_cmd_ready", 32'(cmd_ready), 0);
        tick();
        check("w0_access_penable", 32'(apb_m.PENABLE_PM), 1);
        check("w0_access_rsp_valid", 32'(rsp_valid), 0);
        tick();
        check("w0_rsp_valid", 32'(rsp_valid), 1);
        check("w0_rsp_err", 32'(rsp_err), 0);
        check("w0_rsp_rdata", rsp_rdata, 0);
        check("w0_rsp_timeout", 32'(rsp_timeout), 0);
        check("w0_psel_cycles", psel_cnt - base_sel, 2);
        check("w0_penable_cycles", pen_cnt - base_en, 1);
        rsp_ack();
        check("w0_ack_rsp_valid", 32'(rsp_valid), 0);
        check("w0_ack_cmd_ready", 32'(cmd_ready), 1);
        check("w0_hold_paddr", apb_m.PADDR_PM, 32'h0100_0004);
        check("w0_hold_pwdata", apb_m.PWDATA_PM, 32'hDEAD_BEEF);
        check("w0_hold_pwrite", 32'(apb_m.PWRITE_PM), 1);

        // Read with 5 wait states.
        n_wait = 5; sl_rdata = 32'h1234_5678;
        base_en = pen_cnt;
        issue(1'b0, 32'h0000_0010, 32'h0);
        wait_rsp(50);
        check("r5_penable_cycles", pen_cnt - base_en, 6);
        check("r5_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("r5_rsp_err", 32'(rsp_err), 0);
        check("r5_rsp_timeout", 32'(rsp_timeout), 0);
        rsp_ack();

        // Write answered with a slave error.
        n_wait = 2; sl_err = 1'b1; sl_rdata = 32'h7777_7777;
        base_en = pen_cnt;
        issue(1'b1, 32'h0000_0020, 32'h0000_00AA);
        wait_rsp(50);
        check("werr_penable_cycles", pen_cnt - base_en, 3);
        check("werr_rsp_err", 32'(rsp_err), 1);
        check("werr_rsp_timeout", 32'(rsp_timeout), 0);
        check("werr_rsp_rdata", rsp_rdata, 0);
        rsp_ack();
        sl_err = 1'b0;

        // Slave never ready: abort after 8 ACCESS cycles.
        n_wait = 1000; sl_rdata = 32'hCAFE_F00D;
        base_en = pen_cnt;
        issue(1'b0, 32'h0000_0030, 32'h0);
        wait_rsp(50);
        check("to_penable_cycles", pen_cnt - base_en, 8);
        check("to_rsp_err", 32'(rsp_err), 1);
        check("to_rsp_timeout", 32'(rsp_timeout), 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        rsp_ack();

        // PREADY arrives in the last allowed ACCESS cycle: completion beats timeout.
        n_wait = 7; sl_rdata = 32'h0BAD_F00D;
        base_en = pen_cnt;
        issue(1'b0, 32'h0000_0034, 32'h0);
        wait_rsp(50);
        check("edge_penable_cycles", pen_cnt - base_en, 8);
        check("edge_rsp_timeout", 32'(rsp_timeout), 0);
        check("edge_rsp_err", 32'(rsp_err), 0);
        check("edge_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        rsp_ack();

        // Back-to-back with a 4-cycle response stall, CMD_VALID held throughout.
        n_wait = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h1111_1111;
        tick();
        cmd_addr = 32'h0000_0204; cmd_wdata = 32'h2222_2222;
        wait_rsp(20);
        hi = 0;
        repeat (4) begin
            tick();
            if (cmd_ready) hi++;
        end
        check("b2b_ready_during_stall", hi, 0);
        check("b2b_rsp_valid_held", 32'(rsp_valid), 1);
        rsp_ack();
        check("b2b_ready_after_ack", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_second_paddr", apb_m.PADDR_PM, 32'h0000_0204);
        check("b2b_second_pwdata", apb_m.PWDATA_PM, 32'h2222_2222);
        wait_rsp(20);
        check("b2b_penable_gap", last_gap, 7);
        rsp_ack();

        // Full-rate stream: one transfer every 4 cycles, minimum PENABLE gap of 3.
        base_en = pen_cnt;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0300; cmd_wdata = 32'h3;
        repeat (12) tick();
        cmd_valid = 1'b0;
        drain = 0;
        while (busy && (drain < 10)) begin
            tick();
            drain++;
        end
        rsp_ready = 1'b0;
        check("stream_busy_drained", 32'(busy), 0);
        check("stream_transfers", pen_cnt - base_en, 3);
        check("stream_min_gap", last_gap, 3);

        // Timeout disabled: no abort after 1000 stalled cycles.
        z_cmd_valid = 1'b1; z_cmd_write = 1'b0; z_cmd_addr = 32'h0000_0400;
        tick();
        z_cmd_valid = 1'b0;
        repeat (1000) tick();
        check("nto_rsp_valid", 32'(z_rsp_valid), 0);
        check("nto_penable", 32'(apb_z.PENABLE_PM), 1);
        check("nto_busy", 32'(z_busy), 1);
        apb_z.PREADY_PM = 1'b1; apb_z.PRDATA_PM = 32'h5A5A_0001;
        tick();
        apb_z.PREADY_PM = 1'b0;
        check("nto_late_rsp_valid", 32'(z_rsp_valid), 1);
        check("nto_late_rsp_timeout", 32'(z_rsp_timeout), 0);
        check("nto_late_rsp_rdata", z_rsp_rdata, 32'h5A5A_0001);
        z_rsp_ready = 1'b1;
        tick();
        z_rsp_ready = 1'b0;

        // Reset asserted mid-ACCESS.
        n_wait = 1000;
        issue(1'b0, 32'h0000_0500, 32'h0000_0055);
        repeat (3) tick();
        check("mid_penable_before_rst", 32'(apb_m.PENABLE_PM), 1);
        #3 PRESETN_PM = 1'b0;
        #1;
        check("mid_rst_psel", 32'(apb_m.PSEL_PM), 0);
        check("mid_rst_penable", 32'(apb_m.PENABLE_PM), 0);
        check("mid_rst_paddr", apb_m.PADDR_PM, 0);
        check("mid_rst_pwrite", 32'(apb_m.PWRITE_PM), 0);
        check("mid_rst_pwdata", apb_m.PWDATA_PM, 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        n_wait = 0;
        #3 PRESETN_PM = 1'b1;
        tick();
        tick();
        check("post_rst_rsp_valid", 32'(rsp_valid), 0);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

`ifdef APB_PM_MASTER_STATS_EN
        check("stat_rst_rd", 32'(stat_rd), 0);
        check("stat_rst_wr", 32'(stat_wr), 0);
        simple_xfer(1'b0, 32'h0000_0600);
        simple_xfer(1'b1, 32'h0000_0604);
        simple_xfer(1'b0, 32'h0000_0608);
        simple_xfer(1'b1, 32'h0000_060C);
        simple_xfer(1'b0, 32'h0000_0610);
        check("stat_rd", 32'(stat_rd), 3);
        check("stat_wr", 32'(stat_wr), 2);
        check("stat_err", 32'(stat_err), 0);
        check("stat_to", 32'(stat_to), 0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr_rd", 32'(stat_rd), 0);
        check("stat_clr_wr", 32'(stat_wr), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
